video_mode_ctrl: RTL and testbench
==================================

# video_mode_ctrl

Video mode controller that sits in front of the scandoubler in the `clk_vid` domain. It measures the incoming native timing (pixel clock, syncs, blanks) and qualifies a stable mode over several frames. It sequences the scandoubler's enable and flush so the doubled path is only selected on a locked, consistent mode, and falls back to native pass-through on any mode change or signal loss. Measured totals are exported for the OSD and status registers.

## Interface
Parameters:
- `CNT_W`, 12: width of pixel and line counters and of all measurement outputs.
- `STABLE_FRAMES`, 4: consecutive matching frames required before lock (1..15).
- `TOL`, 2: allowed ± difference in `h_total` between frames, in pixels.

Ports:
- `clk_vid` in 1: video clock; single clock domain.
- `reset_n` in 1: reset, asynchronous, active-low.
- `ce_pix` in 1: native pixel enable, synchronous to `clk_vid`.
- `hs_in`, `vs_in`, `hb_in`, `vb_in` in 1 each: native syncs and blanks, active-high, synchronous to `clk_vid`.
- `force_bypass` in 1: user override; holds the scandoubler disabled.
- `sd_enable` out 1: selects the doubled output path.
- `sd_flush` out 1: one-cycle pulse that clears scandoubler line state before enable.
- `mode_valid` out 1: mode locked; high in SWITCH and RUN.
- `h_total` out CNT_W: `ce_pix` count per line.
- `h_active` out CNT_W: non-blank pixels per line, maximum over the frame.
- `v_total` out CNT_W: lines per frame.
- `v_active` out CNT_W: non-blank lines per frame.
- `state` out 2: IDLE=0, MEASURE=1, SWITCH=2, RUN=3.

## Operation
- Edges:
  - `hs_in` and `vs_in` are registered every `clk_vid` cycle, not gated by `ce_pix`.
  - Rising edge = `~prev & cur`.
- Line counters:
  - `pix_cnt` increments on `ce_pix` and restarts at 0 on each hs edge.
  - `act_cnt` increments on `ce_pix & ~hb_in` and restarts at 0 on each hs edge.
  - On each hs edge, `h_line <= pix_cnt`, and `h_act_max <= max(h_act_max, act_cnt)`.
- Frame counters:
  - `ln_cnt` increments on each hs edge.
  - `vact_cnt` increments on each hs edge where `vb_in == 0`.
  - Both restart at 0 on each vs edge.
- All counters saturate at all-ones and never wrap.
- Frame close, on a vs edge:
  - Candidate = {`h_line`, `h_act_max`, `ln_cnt`, `vact_cnt`}.
  - `h_act_max` is cleared after the candidate is taken.
- Match rule:
  - `|cand.h_total − ref.h_total| <= TOL`.
  - All other fields are exactly equal.
- Same-cycle hs and vs edge: the hs edge is applied first (the line belongs to the closing frame), then the frame closes.
- FSM:
  - IDLE: on a vs edge, go to MEASURE with `stable=0`. No reference exists yet.
  - MEASURE, first frame close: store the candidate as ref.
  - MEASURE, later frame closes: on a match, `stable+1`; on a mismatch, ref = candidate and `stable=0`. When `stable` reaches `STABLE_FRAMES`, go to SWITCH.
  - SWITCH: `sd_flush` is high for exactly the entry cycle. On the next vs edge, go to RUN. A mismatch at that edge goes to MEASURE instead.
  - RUN: check each frame close. A mismatch goes to MEASURE with ref = candidate and `stable=0`.
- Timeout:
  - Applies in any state.
  - Triggers when `pix_cnt` saturates (no hs) or `ln_cnt` saturates (no vs).
  - Effect: go to IDLE, ref invalidated, outputs zeroed.
- `h_total`, `h_active`, `v_total`, `v_active` show ref. They update when ref is written and are 0 in IDLE.

## Timing
- Reset values (asynchronous, on `reset_n` low):
  - `sd_enable=0`, `sd_flush=0`, `mode_valid=0`.
  - All measurement outputs 0, `state=0`.
  - All counters and ref cleared.
- Frame close, FSM transition and ref update occur 1 `clk_vid` after the cycle in which the vs edge is sampled.
- `sd_enable = (state==RUN) & ~force_bypass`, registered:
  - Rises 1 cycle after entering RUN.
  - Falls 1 cycle after leaving RUN or after `force_bypass` asserts.
- `sd_flush` precedes `sd_enable` by at least one full frame.
- `mode_valid` is registered from `state`, with 1-cycle latency.
- Deasserting `reset_n` mid-RUN drops `sd_enable` immediately (asynchronously). Lock then requires `STABLE_FRAMES+1` full frames again.

## Test plan
- Lock:
  - Stimulus: h_total 400 (active 320), v_total 262 (active 240), `STABLE_FRAMES=4`.
  - Required: `sd_flush` pulse 1 cycle after the 6th vs edge; RUN and `sd_enable=1` after the 7th; outputs read 400/320/262/240.
- Jitter:
  - Stimulus: alternate h_total 400/402/398 lines.
  - Required: lock as above, never re-enter MEASURE. With h_total 403, `stable` resets and there is no lock.
- Mode change:
  - Stimulus: in RUN, switch to v_total 312.
  - Required: `sd_enable` low 2 cycles after the vs edge; `state=1`; relock 5 frames later with `v_total=312`.
- Signal loss:
  - Stimulus: stop `hs_in` while in RUN.
  - Required: after 4095 `ce_pix`, `state=0`, `mode_valid=0`, all outputs 0.
- Bypass and reset:
  - Stimulus: `force_bypass=1` in RUN.
  - Required: `sd_enable=0` while `state` stays 3. A `reset_n` pulse mid-line clears everything at once, and the block relocks from IDLE.
- Simultaneous edges:
  - Stimulus: hs and vs rise in the same cycle.
  - Required: `v_total` counts that line; lock matches a reference that counted it.

Source files
------------

// File: rtl/video_mode_ctrl.sv
// rtl/video_mode_ctrl.sv - native video mode measurement and scandoubler sequencing
// Measures line/frame timing, qualifies a stable mode, and gates the doubled path.
module video_mode_ctrl #(
  parameter int CNT_W         = 12,
  parameter int STABLE_FRAMES = 4,
  parameter int TOL           = 2
) (
  input  logic             clk_vid,
  input  logic             reset_n,
  input  logic             ce_pix,
  input  logic             hs_in,
  input  logic             vs_in,
  input  logic             hb_in,
  input  logic             vb_in,
  input  logic             force_bypass,
  output logic             sd_enable,
  output logic             sd_flush,
  output logic             mode_valid,
  output logic [CNT_W-1:0] h_total,
  output logic [CNT_W-1:0] h_active,
  output logic [CNT_W-1:0] v_total,
  output logic [CNT_W-1:0] v_active,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    SWITCH  = 2'd2,
    RUN     = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] TOL_C    = CNT_W'(TOL);
  localparam logic [3:0]       STABLE_C = 4'(STABLE_FRAMES);

  state_e           state_q, state_d;
  logic             hs_q, vs_q;
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d, act_cnt_q, act_cnt_d;
  logic [CNT_W-1:0] h_line_q, h_line_d, h_act_max_q, h_act_max_d;
  logic [CNT_W-1:0] ln_cnt_q, ln_cnt_d, vact_cnt_q, vact_cnt_d;
  logic [CNT_W-1:0] ref_h_q, ref_h_d, ref_ha_q, ref_ha_d;
  logic [CNT_W-1:0] ref_v_q, ref_v_d, ref_va_q, ref_va_d;
  logic             ref_valid_q, ref_valid_d;
  logic [3:0]       stable_q, stable_d;
  logic             sd_enable_q, sd_flush_q, mode_valid_q;
  logic             hs_edge, vs_edge, pix_act, timeout, match, load_ref;
  logic [CNT_W-1:0] cand_h, cand_ha, cand_v, cand_va, h_diff;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // The hs edge is folded into the candidate first, so a line whose hs
  // coincides with vs belongs to the frame that is closing.
  always_comb begin
    hs_edge = hs_in & ~hs_q;
    vs_edge = vs_in & ~vs_q;
    pix_act = ce_pix & ~hb_in;

    cand_h  = hs_edge ? pix_cnt_q : h_line_q;
    cand_ha = (hs_edge && (act_cnt_q > h_act_max_q)) ? act_cnt_q : h_act_max_q;
    cand_v  = hs_edge ? sat_inc(ln_cnt_q) : ln_cnt_q;
    cand_va = (hs_edge && !vb_in) ? sat_inc(vact_cnt_q) : vact_cnt_q;

    pix_cnt_d   = hs_edge ? {{(CNT_W-1){1'b0}}, ce_pix}
                          : (ce_pix ? sat_inc(pix_cnt_q) : pix_cnt_q);
    act_cnt_d   = hs_edge ? {{(CNT_W-1){1'b0}}, pix_act}
                          : (pix_act ? sat_inc(act_cnt_q) : act_cnt_q);
    h_line_d    = cand_h;
    h_act_max_d = vs_edge ? '0 : cand_ha;
    ln_cnt_d    = vs_edge ? '0 : cand_v;
    vact_cnt_d  = vs_edge ? '0 : cand_va;

    h_diff  = (cand_h >= ref_h_q) ? (cand_h - ref_h_q) : (ref_h_q - cand_h);
    match   = ref_valid_q && (h_diff <= TOL_C) && (cand_ha == ref_ha_q) &&
              (cand_v == ref_v_q) && (cand_va == ref_va_q);
    timeout = (pix_cnt_q == CNT_MAX) || (ln_cnt_q == CNT_MAX);
  end

  always_comb begin
    state_d     = state_q;
    stable_d    = stable_q;
    load_ref    = 1'b0;
    ref_valid_d = ref_valid_q;
    ref_h_d     = ref_h_q;
    ref_ha_d    = ref_ha_q;
    ref_v_d     = ref_v_q;
    ref_va_d    = ref_va_q;

    if (timeout) begin
      state_d     = IDLE;
      stable_d    = '0;
      ref_valid_d = 1'b0;
      ref_h_d     = '0;
      ref_ha_d    = '0;
      ref_v_d     = '0;
      ref_va_d    = '0;
    end else if (vs_edge) begin
      case (state_q)
        IDLE: begin
          state_d  = MEASURE;
          stable_d = '0;
        end
        MEASURE: begin
          if (match) begin
            stable_d = stable_q + 4'd1;
            if ((stable_q + 4'd1) == STABLE_C) state_d = SWITCH;
          end else begin
            load_ref = 1'b1;
          end
        end
        SWITCH: begin
          if (match) begin
            state_d = RUN;
          end else begin
            state_d  = MEASURE;
            load_ref = 1'b1;
          end
        end
        RUN: begin
          if (!match) begin
            state_d  = MEASURE;
            load_ref = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase

      if (load_ref) begin
        ref_valid_d = 1'b1;
        stable_d    = '0;
        ref_h_d     = cand_h;
        ref_ha_d    = cand_ha;
        ref_v_d     = cand_v;
        ref_va_d    = cand_va;
      end
    end
  end

  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      hs_q         <= 1'b0;
      vs_q         <= 1'b0;
      pix_cnt_q    <= '0;
      act_cnt_q    <= '0;
      h_line_q     <= '0;
      h_act_max_q  <= '0;
      ln_cnt_q     <= '0;
      vact_cnt_q   <= '0;
      ref_h_q      <= '0;
      ref_ha_q     <= '0;
      ref_v_q      <= '0;
      ref_va_q     <= '0;
      ref_valid_q  <= 1'b0;
      stable_q     <= '0;
      sd_enable_q  <= 1'b0;
      sd_flush_q   <= 1'b0;
      mode_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hs_q         <= hs_in;
      vs_q         <= vs_in;
      pix_cnt_q    <= pix_cnt_d;
      act_cnt_q    <= act_cnt_d;
      h_line_q     <= h_line_d;
      h_act_max_q  <= h_act_max_d;
      ln_cnt_q     <= ln_cnt_d;
      vact_cnt_q   <= vact_cnt_d;
      ref_h_q      <= ref_h_d;
      ref_ha_q     <= ref_ha_d;
      ref_v_q      <= ref_v_d;
      ref_va_q     <= ref_va_d;
      ref_valid_q  <= ref_valid_d;
      stable_q     <= stable_d;
      sd_enable_q  <= (state_q == RUN) & ~force_bypass;
      sd_flush_q   <= (state_d == SWITCH) && (state_q != SWITCH);
      mode_valid_q <= (state_q == SWITCH) || (state_q == RUN);
    end
  end

  assign sd_enable  = sd_enable_q;
  assign sd_flush   = sd_flush_q;
  assign mode_valid = mode_valid_q;
  assign h_total    = ref_h_q;
  assign h_active   = ref_ha_q;
  assign v_total    = ref_v_q;
  assign v_active   = ref_va_q;
  assign state      = state_q;

endmodule

// File: tb/tb_video_mode_ctrl.sv
// tb/tb_video_mode_ctrl.sv - directed scoreboard bench for video_mode_ctrl
`timescale 1ns/1ps
module tb_video_mode_ctrl;

  logic        clk_vid = 1'b0;
  logic        reset_n, ce_pix, hs_in, vs_in, hb_in, vb_in, force_bypass;
  logic        sd_enable, sd_flush, mode_valid;
  logic [11:0] h_total, h_active, v_total, v_active;
  logic [1:0]  state;

  always #5 clk_vid = ~clk_vid;

  video_mode_ctrl #(.CNT_W(12), .STABLE_FRAMES(4), .TOL(2)) dut (
    .clk_vid(clk_vid), .reset_n(reset_n), .ce_pix(ce_pix),
    .hs_in(hs_in), .vs_in(vs_in), .hb_in(hb_in), .vb_in(vb_in),
    .force_bypass(force_bypass), .sd_enable(sd_enable), .sd_flush(sd_flush),
    .mode_valid(mode_valid), .h_total(h_total), .h_active(h_active),
    .v_total(v_total), .v_active(v_active), .state(state)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   jit[7] = '{24, 26, 22, 24, 26, 22, 24};

  logic [1:0] s_state1, s_state2;
  logic       s_flush1, s_flush2, s_en1, s_en2, s_mv1, s_mv2;

  task automatic push(input string tag, input logic [31:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t x;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL sb_underflow: observed %0d required an expectation", obs);
    end else begin
      x = sb.pop_front();
      assert (obs === x.exp) else begin
        n_bad++;
        $error("FAIL %s: observed %0d required %0d", x.tag, obs, x.exp);
      end
    end
  endtask

  task automatic idle(input int n);
    ce_pix = 1'b0; hs_in = 1'b0; vs_in = 1'b0; hb_in = 1'b1; vb_in = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(posedge clk_vid); #1;
    end
  endtask

  // Every frame starts with hs and vs rising in the same cycle.
  task automatic drive_frame(input int h, input int v, input int va);
    for (int i = 0; i < v; i++) begin
      for (int p = 0; p < h; p++) begin
        ce_pix = 1'b1;
        hs_in  = (p < 3);
        vs_in  = (i < 2);
        hb_in  = (p >= 16);
        vb_in  = (i >= va);
        @(posedge clk_vid); #1;
        if (i == 0 && p == 0) begin
          s_state1 = state; s_flush1 = sd_flush; s_en1 = sd_enable; s_mv1 = mode_valid;
        end else if (i == 0 && p == 1) begin
          s_state2 = state; s_flush2 = sd_flush; s_en2 = sd_enable; s_mv2 = mode_valid;
        end
      end
    end
  endtask

  task automatic lock_seq(input string pfx);
    for (int k = 0; k < 7; k++) begin
      push({pfx, "_state"}, (k < 5) ? 1 : ((k == 5) ? 2 : 3));
      drive_frame(24, 14, 12);
      chk(s_state1);
    end
    push({pfx, "_en_entry"}, 0); chk(s_en1);
    push({pfx, "_en_next"}, 1);  chk(s_en2);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; force_bypass = 1'b0;
    idle(4);
    push("rst_state", 0);      chk(state);
    push("rst_sd_enable", 0);  chk(sd_enable);
    push("rst_sd_flush", 0);   chk(sd_flush);
    push("rst_mode_valid", 0); chk(mode_valid);
    push("rst_h_total", 0);    chk(h_total);
    push("rst_v_total", 0);    chk(v_total);
    reset_n = 1'b1;
    idle(4);

    // Lock: frames 1..7 with flush/enable timing on frames 6 and 7.
    for (int k = 0; k < 5; k++) begin
      push("lock_measure", 1);
      drive_frame(24, 14, 12);
      chk(s_state1);
    end
    push("lock_switch", 2);     push("flush_entry", 1); push("flush_one_cycle", 0);
    push("mv_lat0", 0);         push("mv_lat1", 1);     push("switch_hold", 2);
    drive_frame(24, 14, 12);
    chk(s_state1); chk(s_flush1); chk(s_flush2); chk(s_mv1); chk(s_mv2); chk(s_state2);
    push("lock_run", 3); push("run_en_entry", 0); push("run_en_next", 1); push("run_flush", 0);
    drive_frame(24, 14, 12);
    chk(s_state1); chk(s_en1); chk(s_en2); chk(s_flush1);
    push("h_total", 24);         chk(h_total);
    push("h_active", 16);        chk(h_active);
    push("simul_v_total", 14);   chk(v_total);
    push("v_active", 12);        chk(v_active);

    // Bypass holds the doubled path off while the mode stays locked.
    force_bypass = 1'b1;
    push("byp_state", 3); push("byp_en", 0);
    drive_frame(24, 14, 12);
    chk(s_state1); chk(s_en1);
    force_bypass = 1'b0;
    push("byp_release_en", 1);
    drive_frame(24, 14, 12);
    chk(s_en1);

    // Asynchronous reset in the middle of a line.
    for (int k = 0; k < 3 * 24 + 5; k++) begin
      ce_pix = 1'b1; hs_in = ((k % 24) < 3); vs_in = ((k / 24) < 2);
      hb_in = ((k % 24) >= 16); vb_in = 1'b0;
      @(posedge clk_vid); #1;
    end
    push("pre_rst_en", 1); chk(sd_enable);
    #2 reset_n = 1'b0; #1;
    push("arst_en", 0);    chk(sd_enable);
    push("arst_state", 0); chk(state);
    push("arst_mv", 0);    chk(mode_valid);
    push("arst_h_total", 0); chk(h_total);
    push("arst_v_active", 0); chk(v_active);
    idle(3);
    reset_n = 1'b1;
    idle(3);
    lock_seq("relock");

    // Mode change to 16 lines per frame.
    push("mc_first_run", 3);
    drive_frame(24, 16, 14);
    chk(s_state1);
    push("mc_measure", 1); push("mc_en_hold", 1); push("mc_en_drop", 0);
    drive_frame(24, 16, 14);
    chk(s_state1); chk(s_en1); chk(s_en2);
    push("mc_v_total", 16);  chk(v_total);
    push("mc_v_active", 14); chk(v_active);
    for (int k = 0; k < 3; k++) begin
      push("mc_remeasure", 1);
      drive_frame(24, 16, 14);
      chk(s_state1);
    end
    push("mc_switch", 2);
    drive_frame(24, 16, 14);
    chk(s_state1);
    push("mc_run", 3); push("mc_en", 1);
    drive_frame(24, 16, 14);
    chk(s_state1); chk(s_en2);

    // Signal loss: hs stops, pix_cnt saturates after 4095 pixels.
    ce_pix = 1'b1; hs_in = 1'b1; vs_in = 1'b1; hb_in = 1'b0; vb_in = 1'b0;
    @(posedge clk_vid); #1;
    hs_in = 1'b0; vs_in = 1'b0;
    for (int k = 0; k < 4094; k++) begin
      @(posedge clk_vid); #1;
    end
    push("loss_before", 3); chk(state);
    @(posedge clk_vid); #1;
    push("loss_state", 0);    chk(state);
    push("loss_h_total", 0);  chk(h_total);
    push("loss_h_active", 0); chk(h_active);
    push("loss_v_total", 0);  chk(v_total);
    push("loss_v_active", 0); chk(v_active);
    @(posedge clk_vid); #1;
    push("loss_mv", 0); chk(mode_valid);
    push("loss_en", 0); chk(sd_enable);

    // Jitter within TOL locks and holds; 27 vs 24 breaks it.
    idle(2);
    hs_in = 1'b1; @(posedge clk_vid); #1;
    idle(4);
    for (int k = 0; k < 7; k++) begin
      push("jit_lock", (k < 5) ? 1 : ((k == 5) ? 2 : 3));
      drive_frame(jit[k], 14, 12);
      chk(s_state1);
    end
    for (int k = 0; k < 3; k++) begin
      push("jit_hold", 3);
      drive_frame((k == 1) ? 22 : 26, 14, 12);
      chk(s_state1);
    end
    push("jit_ref_h", 24); chk(h_total);
    push("jit_pre_break", 3);
    drive_frame(27, 14, 12);
    chk(s_state1);
    push("jit_break", 1);
    drive_frame(24, 14, 12);
    chk(s_state1);
    push("jit_new_ref_h", 27); chk(h_total);
    for (int k = 0; k < 6; k++) begin
      push("jit_no_lock", 1);
      drive_frame((k % 2 == 0) ? 27 : 24, 14, 12);
      chk(s_state1);
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
